dmem_io_ctrl: RTL and testbench
===============================

// Module: dmem_io_ctrl
// PURPOSE
//  Parametrised data memory + memory-mapped IO controller for the 16-bit MIPS datapath, next generation of the data memory/IO block.
//  Adds a req/ack handshake, a registered 1-cycle read, an LED port, debounced switches and a latched pushbutton with a press counter.
//  Sits between the datapath load/store stage and the board IO.
// PARAMETERS
//  DATA_W    16   word width in bits (>=16)
//  ADDR_W    16   byte address width
//  DEPTH     128  memory words; power of 2; 2*DEPTH <= 2^ADDR_W - 8
//  LED_W     8    LED port width (<= DATA_W)
//  SW_W      2    switch count (<= DATA_W)
//  DEBOUNCE  4    cycles a synchronised input must hold stable before acceptance (>=1)
// PORTS
//  clock       in   1        clock; all state updates on posedge
//  reset       in   1        synchronous, active-high
//  req         in   1        access request, sampled each posedge
//  we          in   1        1 = write, 0 = read; qualified by req
//  addr        in   ADDR_W   byte address; bit 0 ignored (word aligned, big endian)
//  wdata       in   DATA_W   write data
//  rdata       out  DATA_W   read data; valid only while ack=1, else 0
//  ack         out  1        completion pulse, 1 cycle after an accepted req
//  io_display  out  7        seven-seg {a,b,c,d,e,f,g}
//  io_led      out  LED_W    LED register
//  io_sw       in   SW_W     raw sliding switches (asynchronous)
//  io_pb       in   1        raw pushbutton (asynchronous)
// BEHAVIOUR
//  Reset: ack, rdata, io_display, io_led, pb_pending, press_cnt, sync/debounce state all cleared to 0; memory not cleared.
//  While reset=1: req ignored, no memory/IO writes, ack=0 on the following cycle.
//  Address map (T = 2^ADDR_W):
//  - 0 .. 2*DEPTH-1  memory word addr[log2(DEPTH):1]
//  - T-8 display, R/W, wdata[6:0]
//  - T-6 LED, R/W, wdata[LED_W-1:0]
//  - T-4 PB status, read {press_cnt[7:0] in [15:8], 0s, pb_level in [1], pb_pending in [0]}; write wdata[0]=1 clears pb_pending
//  - T-2 switches, read-only, debounced sw zero-extended
//  - Any other address: read returns 0; write ignored.
//  Handshake:
//  - Every posedge with req=1 (and reset=0) accepts one access; no stall, throughput 1/cycle.
//  - ack=1 exactly the next cycle; rdata = read result in that cycle, 0 for writes.
//  - Writes commit at the accepting edge; a read accepted the next cycle sees the new value.
//  - Read and write of the same address are never simultaneous (single port).
//  Inputs:
//  - io_sw and io_pb pass through 2-flop synchronisers.
//  - The debounced value updates only after the synchronised value differs from it for DEBOUNCE consecutive cycles.
//  - Any bounce restarts the count.
//  Pushbutton:
//  - Debounced 0->1 edge sets pb_pending and increments press_cnt (8-bit, wraps 255->0).
//  - Clear write and a new edge in the same cycle: pb_pending stays 1, the count still increments.
//  Widths: DATA_W bits above the defined fields read as 0; LED/display writes truncate wdata.
// TESTING (sim with DEBOUNCE=4)
//  1. Reset, then req/we=1 addr 0x0004 wdata 0xBEEF; next cycle read 0x0004 -> ack pulses each cycle, rdata 0xBEEF one cycle after the read req.
//  2. Write 0x1234 to 0x0000 and 0x5678 to 0x00FE; read both -> 0x1234, 0x5678. Read 0x0100 -> 0. Write 0x0100 does not alias word 0.
//  3. Write 0x005B to 0xFFF8 and 0x00A5 to 0xFFFA -> io_display=7'b1011011, io_led=8'hA5; reading back returns the same values.
//  4. io_sw=2'b10 toggling every 2 cycles, then held -> read 0xFFFE stays 0x0000 during the bounce, becomes 0x0002 at 2+4 cycles after the hold.
//  5. Three clean io_pb presses -> read 0xFFFC=0x0301 (bit1 follows the button); write 0x0001 -> 0x0300; clear coinciding with a 4th edge -> 0x0401.
//  6. Assert reset while a read is accepted -> ack=0 next cycle, display/LED=0, memory contents retained.

Source files
------------

// File: rtl/dmem_io_ctrl.sv
// Data memory plus memory-mapped IO (seven-seg, LEDs, debounced switches, latched pushbutton)
// for the 16-bit MIPS load/store stage, with a req/ack handshake and a registered 1-cycle read.
module dmem_io_ctrl #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 128,
  parameter int LED_W    = 8,
  parameter int SW_W     = 2,
  parameter int DEBOUNCE = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              ack_o,
  output logic [6:0]        io_display_o,
  output logic [LED_W-1:0]  io_led_o,
  input  logic [SW_W-1:0]   io_sw_i,
  input  logic              io_pb_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q, rdata_d, readVal;
  logic              ack_q;
  logic [6:0]        display_q;
  logic [LED_W-1:0]  led_q;
  logic [SW_W-1:0]   swSync1_q, swSync2_q, swDeb_q, swDeb_d;
  logic [CW-1:0]     swCnt_q, swCnt_d;
  logic              pbSync1_q, pbSync2_q, pbDeb_q, pbDeb_d;
  logic [CW-1:0]     pbCnt_q, pbCnt_d;
  logic              pbPending_q, pbPending_d;
  logic [7:0]        pressCnt_q, pressCnt_d;
  logic              accept, isMem, isIo, wrAccept;
  logic              wrDisplay, wrLed, wrPbClear, pbRise;
  logic [AW-1:0]     wordIdx;
  logic              unusedAddrBit0;

  assign unusedAddrBit0 = addr_i[0];

  // IO registers live in the top 8 bytes; addr[2:1] picks display/LED/PB/switches
  assign accept    = req_i & ~reset;
  assign wrAccept  = accept & we_i;
  assign isMem     = (addr_i[ADDR_W-1:AW+1] == '0);
  assign isIo      = &addr_i[ADDR_W-1:3];
  assign wordIdx   = addr_i[AW:1];
  assign wrDisplay = wrAccept & isIo & (addr_i[2:1] == 2'd0);
  assign wrLed     = wrAccept & isIo & (addr_i[2:1] == 2'd1);
  assign wrPbClear = wrAccept & isIo & (addr_i[2:1] == 2'd2) & wdata_i[0];

  always_comb begin
    readVal = '0;
    if (isMem) begin
      readVal = mem[wordIdx];
    end else if (isIo) begin
      case (addr_i[2:1])
        2'd0: readVal[6:0] = display_q;
        2'd1: readVal[LED_W-1:0] = led_q;
        2'd2: begin
          readVal[15:8] = pressCnt_q;
          readVal[1]    = pbDeb_q;
          readVal[0]    = pbPending_q;
        end
        2'd3: readVal[SW_W-1:0] = swDeb_q;
      endcase
    end
    rdata_d = (accept && !we_i) ? readVal : '0;
  end

  // Counter only advances while the synchronised value disagrees; any return resets it
  always_comb begin
    swDeb_d = swDeb_q;
    swCnt_d = '0;
    if (swSync2_q != swDeb_q) begin
      if (swCnt_q == CNT_LAST) swDeb_d = swSync2_q;
      else                     swCnt_d = swCnt_q + 1'b1;
    end
    pbDeb_d = pbDeb_q;
    pbCnt_d = '0;
    if (pbSync2_q != pbDeb_q) begin
      if (pbCnt_q == CNT_LAST) pbDeb_d = pbSync2_q;
      else                     pbCnt_d = pbCnt_q + 1'b1;
    end
  end

  // A new press wins over a simultaneous clear so no press is lost
  always_comb begin
    pbRise      = pbDeb_d & ~pbDeb_q;
    pbPending_d = pbPending_q;
    if (wrPbClear) pbPending_d = 1'b0;
    if (pbRise)    pbPending_d = 1'b1;
    pressCnt_d  = pressCnt_q + {7'd0, pbRise};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      display_q   <= '0;
      led_q       <= '0;
      swSync1_q   <= '0;
      swSync2_q   <= '0;
      swDeb_q     <= '0;
      swCnt_q     <= '0;
      pbSync1_q   <= 1'b0;
      pbSync2_q   <= 1'b0;
      pbDeb_q     <= 1'b0;
      pbCnt_q     <= '0;
      pbPending_q <= 1'b0;
      pressCnt_q  <= '0;
    end else begin
      rdata_q     <= rdata_d;
      ack_q       <= req_i;
      if (wrDisplay) display_q <= wdata_i[6:0];
      if (wrLed)     led_q     <= wdata_i[LED_W-1:0];
      swSync1_q   <= io_sw_i;
      swSync2_q   <= swSync1_q;
      swDeb_q     <= swDeb_d;
      swCnt_q     <= swCnt_d;
      pbSync1_q   <= io_pb_i;
      pbSync2_q   <= pbSync1_q;
      pbDeb_q     <= pbDeb_d;
      pbCnt_q     <= pbCnt_d;
      pbPending_q <= pbPending_d;
      pressCnt_q  <= pressCnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wrAccept && isMem) mem[wordIdx] <= wdata_i;
  end

  assign rdata_o      = rdata_q;
  assign ack_o        = ack_q;
  assign io_display_o = display_q;
  assign io_led_o     = led_q;

endmodule

// File: tb/tb_dmem_io_ctrl.sv
// Scoreboard bench for dmem_io_ctrl: directed scenarios followed by random traffic,
// checked against a behavioural model of the memory map, debouncers and button latch.
module tb_dmem_io_ctrl;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int DEPTH    = 128;
  localparam int LED_W    = 8;
  localparam int SW_W     = 2;
  localparam int DEBOUNCE = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, we = 1'b0;
  logic [15:0] addr = '0, wdata = '0;
  logic [15:0] rdata;
  logic        ack;
  logic [6:0]  disp;
  logic [7:0]  led;
  logic [1:0]  sw = '0;
  logic        pb = 1'b0;

  dmem_io_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
    .LED_W(LED_W), .SW_W(SW_W), .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clock(clock), .reset(reset), .req_i(req), .we_i(we), .addr_i(addr),
    .wdata_i(wdata), .rdata_o(rdata), .ack_o(ack), .io_display_o(disp),
    .io_led_o(led), .io_sw_i(sw), .io_pb_i(pb)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          stamp;
    logic [15:0] data;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;
  int   edgeCnt = 0;
  int   modelEdgeCnt = 0;

  logic [15:0] mMem [DEPTH];
  logic [6:0]  mDisp = '0;
  logic [7:0]  mLed = '0;
  logic        mPending = 1'b0;
  logic [7:0]  mPress = '0;
  logic [1:0]  mSw1 = '0, mSw2 = '0, mSwDeb = '0;
  logic        mPb1 = 1'b0, mPb2 = 1'b0, mPbDeb = 1'b0;
  int          mSwRun = 0;
  int          mPbRun = 0;

  function automatic logic [15:0] modelRead(input logic [15:0] a);
    if (int'(a) < 2 * DEPTH) return mMem[int'(a >> 1)];
    case (a & 16'hFFFE)
      16'hFFF8: return {9'd0, mDisp};
      16'hFFFA: return {8'd0, mLed};
      16'hFFFC: return {mPress, 6'd0, mPbDeb, mPending};
      16'hFFFE: return {14'd0, mSwDeb};
      default:  return 16'h0000;
    endcase
  endfunction

  // Advances the model by one clock edge using the inputs currently driven
  task automatic modelEdge();
    exp_t e;
    modelEdgeCnt++;
    if (reset) begin
      mDisp = '0; mLed = '0; mPending = 1'b0; mPress = '0;
      mSw1 = '0; mSw2 = '0; mSwDeb = '0; mSwRun = 0;
      mPb1 = 1'b0; mPb2 = 1'b0; mPbDeb = 1'b0; mPbRun = 0;
      return;
    end
    if (req) begin
      e.stamp = modelEdgeCnt;
      e.data  = we ? 16'h0000 : modelRead(addr);
      expQ.push_back(e);
      if (we) begin
        if (int'(addr) < 2 * DEPTH) mMem[int'(addr >> 1)] = wdata;
        else case (addr & 16'hFFFE)
          16'hFFF8: mDisp = wdata[6:0];
          16'hFFFA: mLed = wdata[7:0];
          16'hFFFC: if (wdata[0]) mPending = 1'b0;
          default: ;
        endcase
      end
    end
    if (mSw2 != mSwDeb) begin
      mSwRun++;
      if (mSwRun == DEBOUNCE) begin mSwDeb = mSw2; mSwRun = 0; end
    end else mSwRun = 0;
    if (mPb2 != mPbDeb) begin
      mPbRun++;
      if (mPbRun == DEBOUNCE) begin
        mPbDeb = mPb2;
        mPbRun = 0;
        if (mPbDeb) begin mPending = 1'b1; mPress = mPress + 8'd1; end
      end
    end else mPbRun = 0;
    mSw2 = mSw1; mSw1 = sw;
    mPb2 = mPb1; mPb1 = pb;
  endtask

  task automatic applyStimulus(input logic rst, input logic rq, input logic w,
                               input logic [15:0] a, input logic [15:0] d);
    reset = rst; req = rq; we = w; addr = a; wdata = d;
    modelEdge();
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, expv, $time);
    end
  endtask

  always @(posedge clock) edgeCnt++;

  // Monitor: an expected response due at this edge must show as ack with its data
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (expQ.size() > 0 && expQ[0].stamp <= edgeCnt) begin
        e = expQ.pop_front();
        checkOutput("ack", {15'd0, ack}, 16'd1);
        checkOutput("rdata", rdata, e.data);
      end else begin
        checkOutput("ack_idle", {15'd0, ack}, 16'd0);
        checkOutput("rdata_idle", rdata, 16'h0000);
      end
      checkOutput("display", {9'd0, disp}, {9'd0, mDisp});
      checkOutput("led", {8'd0, led}, {8'd0, mLed});
    end
  end

  initial begin
    int r;
    logic [15:0] a;
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b1, 16'(2 * i), 16'($urandom));

    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0004, 16'hBEEF);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000);

    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0000, 16'h1234);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h00FE, 16'h5678);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h00FE, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'h0100, 16'hDEAD);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0101, 16'h0000);

    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFF8, 16'h005B);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFA, 16'h00A5);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFF8, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFA, 16'h0000);

    for (int k = 0; k < 10; k++) begin
      sw = k[1] ? 2'b10 : 2'b00;
      applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0000);
    end
    sw = 2'b10;
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFE, 16'h0000);

    for (int p = 0; p < 3; p++) begin
      if (p == 1) for (int b = 0; b < 5; b++) begin pb = b[0]; idle(1); end
      pb = 1'b1; idle(8);
      applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFC, 16'h0000);
      pb = 1'b0; idle(8);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFC, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFC, 16'h0001);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFC, 16'h0000);
    pb = 1'b1; idle(5);
    applyStimulus(1'b0, 1'b1, 1'b1, 16'hFFFC, 16'h0001);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFC, 16'h0000);
    pb = 1'b0; idle(8);

    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0004, 16'h0000);
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h00FE, 16'h0000);

    // Enough presses to carry the press counter through 255 -> 0
    for (int p = 0; p < 258; p++) begin
      pb = 1'b1; idle(6);
      pb = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b0, 16'hFFFC, 16'h0000);
      idle(5);
    end

    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 7) == 0) sw = 2'($urandom);
      if ($urandom_range(0, 5) == 0) pb = ~pb;
      r = int'($urandom_range(0, 99));
      if (r < 60)      a = 16'($urandom_range(0, 2 * DEPTH - 1));
      else if (r < 85) a = 16'hFFF8 + 16'($urandom_range(0, 7));
      else             a = 16'($urandom_range(2 * DEPTH, 32'hFFF7));
      applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7,
                    $urandom_range(0, 9) < 4, a, 16'($urandom));
    end

    idle(4);
    checkOutput("queue_drained", 16'(expQ.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
